bird_flight_ctrl: RTL and testbench

//  Sequencer for the bird column (ROWS stacked bird-light cells sharing press/gravity).

---
 rtl/bird_flight_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_bird_flight_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bird_flight_ctrl.sv
// ---------------------------------------------------------------------------
// bird_flight_ctrl
//   Sequencer for the bird column: ROWS stacked bird-light cells that share one
//   move-up (press) and one move-down (gravity) strobe. Cleans up the raw flap
//   key into single-cycle press pulses, paces gravity ticks, tracks the bird
//   height and runs the IDLE/PLAY/DEAD game state machine, including the
//   one-cycle column clear on restart.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   key_i        in   raw flap key (asynchronous, active-high)
//   collide_i    in   pipe collision flag, only looked at in PLAY
//   press_o      out  one-cycle move-up pulse to the column cells
//   gravity_o    out  one-cycle move-down pulse to the column cells
//   col_clear_o  out  one-cycle clear pulse for the column cells
//   bird_pos_o   out  bird height: 0 = off-screen, 1 = bottom ... ROWS = top
//   playing_o    out  high while in PLAY
//   game_over_o  out  high while in DEAD
// ---------------------------------------------------------------------------
module bird_flight_ctrl #(
  parameter int ROWS        = 8,
  parameter int GRAV_PERIOD = 24,
  localparam int POS_W      = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_i,
  input  logic             collide_i,
  output logic             press_o,
  output logic             gravity_o,
  output logic             col_clear_o,
  output logic [POS_W-1:0] bird_pos_o,
  output logic             playing_o,
  output logic             game_over_o
);

  localparam int               CNT_W    = $clog2(GRAV_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAV_PERIOD - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(ROWS);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t           state_q;
  logic             press_q;
  logic             gravity_q;
  logic             col_clear_q;
  logic [POS_W-1:0] bird_pos_q;
  logic             playing_q;
  logic             game_over_q;
  logic [CNT_W-1:0] grav_cnt_q;
  logic [CNT_W-1:0] grav_cnt_d;
  logic             grav_pend_q;

  // ---------------------------------------------------------------------
  // Key synchroniser and rising-edge detect.
  // key_arm_q means "the previous synchronised sample was a genuine low".
  // The synchroniser flops come out of reset at 0, which is not a real
  // observation of the key, so sync_vld_q holds off arming until the chain
  // carries real samples. A key held high across reset therefore has to be
  // released and pressed again before it produces an edge.
  // ---------------------------------------------------------------------
  logic       key_s1_q;
  logic       key_s2_q;
  logic [1:0] sync_vld_q;
  logic       key_arm_q;
  logic       key_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      sync_vld_q <= 2'b00;
      key_arm_q  <= 1'b0;
    end else begin
      key_s1_q   <= key_i;
      key_s2_q   <= key_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      key_arm_q  <= sync_vld_q[1] & ~key_s2_q;
    end
  end

  assign key_edge = key_s2_q & key_arm_q;

  // ---------------------------------------------------------------------
  // Gravity pacing and per-cycle decisions in PLAY.
  // ---------------------------------------------------------------------
  logic grav_tick;
  logic do_press;
  logic grav_due;

  always_comb begin
    grav_cnt_d = grav_cnt_q + CNT_W'(1);
    if (grav_cnt_q == CNT_LAST) begin
      grav_cnt_d = '0;
    end
  end

  assign grav_tick = (state_q == S_PLAY) && (grav_cnt_q == CNT_LAST);
  // A flap at the ceiling is dropped entirely, so it cannot defer gravity.
  assign do_press  = key_edge && (bird_pos_q != POS_MAX);
  assign grav_due  = grav_tick || grav_pend_q;

  // ---------------------------------------------------------------------
  // Game state machine with registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      press_q     <= 1'b0;
      gravity_q   <= 1'b0;
      col_clear_q <= 1'b0;
      bird_pos_q  <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      grav_cnt_q  <= '0;
      grav_pend_q <= 1'b0;
    end else begin
      press_q     <= 1'b0;
      gravity_q   <= 1'b0;
      col_clear_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Counter held at 0 so the first tick lands GRAV_PERIOD cycles
          // after PLAY entry.
          grav_cnt_q  <= '0;
          grav_pend_q <= 1'b0;
          if (key_edge) begin
            state_q    <= S_PLAY;
            press_q    <= 1'b1;
            bird_pos_q <= POS_ONE;
            playing_q  <= 1'b1;
          end
        end

        S_PLAY: begin
          grav_cnt_q <= grav_cnt_d;
          if (collide_i) begin
            // Collision overrides any flap or tick in the same cycle.
            state_q     <= S_DEAD;
            playing_q   <= 1'b0;
            game_over_q <= 1'b1;
            grav_pend_q <= 1'b0;
          end else if (do_press) begin
            // Press wins; a coincident or already pending tick is held over
            // as a single pending tick.
            press_q     <= 1'b1;
            bird_pos_q  <= bird_pos_q + POS_ONE;
            grav_pend_q <= grav_due;
          end else if (grav_due) begin
            gravity_q   <= 1'b1;
            grav_pend_q <= 1'b0;
            if (bird_pos_q != '0) begin
              bird_pos_q <= bird_pos_q - POS_ONE;
            end
            if (bird_pos_q <= POS_ONE) begin
              state_q     <= S_DEAD;
              playing_q   <= 1'b0;
              game_over_q <= 1'b1;
            end
          end
        end

        S_DEAD: begin
          grav_cnt_q  <= '0;
          grav_pend_q <= 1'b0;
          // Restart only clears the column; a further flap starts play.
          if (key_edge) begin
            state_q     <= S_IDLE;
            col_clear_q <= 1'b1;
            bird_pos_q  <= '0;
            game_over_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          playing_q   <= 1'b0;
          game_over_q <= 1'b0;
          bird_pos_q  <= '0;
          grav_cnt_q  <= '0;
          grav_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign press_o     = press_q;
  assign gravity_o   = gravity_q;
  assign col_clear_o = col_clear_q;
  assign bird_pos_o  = bird_pos_q;
  assign playing_o   = playing_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_bird_flight_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bird_flight_ctrl
//   Directed bench for bird_flight_ctrl with ROWS=4, GRAV_PERIOD=4. Each call
//   of cyc() drives the key/collision inputs sampled at the next rising edge
//   and compares every output just after that edge against hand-derived values.
// ---------------------------------------------------------------------------
module tb_bird_flight_ctrl;

  localparam int ROWS        = 4;
  localparam int GRAV_PERIOD = 4;
  localparam int POS_W       = $clog2(ROWS + 1);

  logic             clk;
  logic             reset;
  logic             key_i;
  logic             collide_i;
  logic             press_o;
  logic             gravity_o;
  logic             col_clear_o;
  logic [POS_W-1:0] bird_pos_o;
  logic             playing_o;
  logic             game_over_o;

  int n_chk;
  int n_bad;
  int cyc_no;

  bird_flight_ctrl #(
    .ROWS        (ROWS),
    .GRAV_PERIOD (GRAV_PERIOD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_i       (key_i),
    .collide_i   (collide_i),
    .press_o     (press_o),
    .gravity_o   (gravity_o),
    .col_clear_o (col_clear_o),
    .bird_pos_o  (bird_pos_o),
    .playing_o   (playing_o),
    .game_over_o (game_over_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc_no, got, exp);
    end
  endtask

  // Drive inputs for the next edge, advance one clock, then check all outputs.
  task automatic cyc(input logic k, input logic c,
                     input logic exp_press, input logic exp_grav, input int exp_pos,
                     input logic exp_play, input logic exp_over, input logic exp_clr);
    key_i     = k;
    collide_i = c;
    @(posedge clk);
    #1;
    cyc_no++;
    $display("cyc %0d rst=%0b key=%0b col=%0b -> press=%0b grav=%0b clr=%0b pos=%0d play=%0b over=%0b",
             cyc_no, reset, k, c, press_o, gravity_o, col_clear_o, bird_pos_o,
             playing_o, game_over_o);
    check_eq("press",   int'(press_o),     int'(exp_press));
    check_eq("gravity", int'(gravity_o),   int'(exp_grav));
    check_eq("pos",     int'(bird_pos_o),  exp_pos);
    check_eq("playing", int'(playing_o),   int'(exp_play));
    check_eq("over",    int'(game_over_o), int'(exp_over));
    check_eq("clear",   int'(col_clear_o), int'(exp_clr));
    check_eq("excl",    int'(press_o & gravity_o), 0);
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    cyc_no    = 0;
    reset     = 1'b1;
    key_i     = 1'b0;
    collide_i = 1'b0;

    // Reset state
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0,0, 0,0,0, 0,0,0);

    // Game 1: start (press two edges after the sampled rise), then fall.
    cyc(1,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(0,0, 1,0,1, 1,0,0);               // PLAY entry
    for (int i = 0; i < 3; i++) cyc(0,0, 0,0,1, 1,0,0);
    cyc(0,0, 0,1,0, 0,1,0);               // first tick: 1->0, DEAD
    cyc(0,0, 0,0,0, 0,1,0);
    // Key in DEAD: column clear, back to IDLE, no play start.
    cyc(1,0, 0,0,0, 0,1,0);
    cyc(0,0, 0,0,0, 0,1,0);
    cyc(0,0, 0,0,0, 0,0,1);
    for (int i = 0; i < 3; i++) cyc(0,0, 0,0,0, 0,0,0);

    // Game 2: flap every 2 cycles; tick/press collisions and the ceiling.
    cyc(1,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(1,0, 1,0,1, 1,0,0);               // entry
    cyc(0,0, 0,0,1, 1,0,0);
    cyc(1,0, 1,0,2, 1,0,0);
    cyc(0,0, 0,0,2, 1,0,0);
    cyc(1,0, 1,0,3, 1,0,0);               // flap on a tick at pos 2: press wins
    cyc(0,0, 0,1,2, 1,0,0);               // deferred gravity
    cyc(1,0, 1,0,3, 1,0,0);
    cyc(0,0, 0,0,3, 1,0,0);
    cyc(1,0, 1,0,4, 1,0,0);               // reaches top, tick deferred
    cyc(0,0, 0,1,3, 1,0,0);
    cyc(1,0, 1,0,4, 1,0,0);
    cyc(0,0, 0,0,4, 1,0,0);
    cyc(0,0, 0,1,3, 1,0,0);               // flap at ceiling dropped, tick goes out
    cyc(0,0, 0,0,3, 1,0,0);

    // Reset mid-PLAY at pos 3 with the key held high across release.
    reset = 1'b1;
    cyc(1,0, 0,0,0, 0,0,0);
    cyc(1,0, 0,0,0, 0,0,0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(1,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(1,0, 1,0,1, 1,0,0);               // fresh press after release + re-press

    // Game 3: collision coinciding with a flap edge.
    cyc(0,0, 0,0,1, 1,0,0);
    cyc(0,1, 0,0,1, 0,1,0);               // collision wins, no press
    cyc(0,0, 0,0,1, 0,1,0);               // height frozen in DEAD
    cyc(1,0, 0,0,1, 0,1,0);
    cyc(0,0, 0,0,1, 0,1,0);
    cyc(0,0, 0,0,0, 0,0,1);               // clear, IDLE, pos 0
    cyc(0,0, 0,0,0, 0,0,0);
    cyc(0,0, 0,0,0, 0,0,0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
